// File: rtl/acc_lut_search_if.sv
// acc_lut_search_if: request/result handshake and LUT access signals of the reverse-lookup engine
interface acc_lut_search_if #(
    parameter int KEY_W = 5,
    parameter int VAL_W = 8
);
    logic             start;
    logic [VAL_W-1:0] target;
    logic             lut_en;
    logic [KEY_W-1:0] lut_key;
    logic [VAL_W-1:0] lut_value;
    logic             busy;
    logic             done;
    logic             hit;
    logic [KEY_W-1:0] key_out;

    modport slave (
        input  start, target, lut_value,
        output lut_en, lut_key, busy, done, hit, key_out
    );

    modport master (
        output start, target, lut_value,
        input  lut_en, lut_key, busy, done, hit, key_out
    );
endinterface

// File: rtl/acc_lut_search.sv
// acc_lut_search: scans LUT keys 0..2^KEY_W-1 and reports the lowest key whose value equals the target; define ACC_LUT_SEARCH_REGIN_EN to register lut_value before the compare
module acc_lut_search #(
    parameter int KEY_W = 5,
    parameter int VAL_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    acc_lut_search_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [KEY_W-1:0] LAST = {KEY_W{1'b1}};

    state_t           state_q, state_d;
    logic [KEY_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [VAL_W-1:0] tgt_q, tgt_d;
    logic             hit_q, hit_d;
    logic             cmp_vld;
    logic             cmp_eq;
    logic [KEY_W-1:0] cmp_key;
    logic             cmp_last;

`ifdef ACC_LUT_SEARCH_REGIN_EN
    logic [VAL_W-1:0] val_q;
    logic [KEY_W-1:0] pkey_q;
    logic             pvld_q;

    // capture the LUT response together with the key that produced it; valid only for SCAN cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q  <= '0;
            pkey_q <= '0;
            pvld_q <= 1'b0;
        end else begin
            val_q  <= bus.lut_value;
            pkey_q <= cnt_q;
            pvld_q <= state_q == SCAN;
        end
    end

    assign cmp_vld = pvld_q;
    assign cmp_eq  = val_q == tgt_q;
    assign cmp_key = pkey_q;
`else
    assign cmp_vld = 1'b1;
    assign cmp_eq  = bus.lut_value == tgt_q;
    assign cmp_key = cnt_q;
`endif

    assign cmp_last = cmp_key == LAST;

    // state, scan counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            tgt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            tgt_q   <= tgt_d;
            hit_q   <= hit_d;
        end
    end

    // accept in IDLE, step one key per SCAN cycle without wrapping, first match or last key ends the scan
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        tgt_d   = tgt_q;
        hit_d   = hit_q;
        if (state_q == IDLE && bus.start) begin
            state_d = SCAN;
            cnt_d   = '0;
            tgt_d   = bus.target;
            hit_d   = 1'b0;
            key_d   = '0;
        end else if (state_q == SCAN) begin
            cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
            if (cmp_vld && cmp_eq) begin
                state_d = DONE;
                hit_d   = 1'b1;
                key_d   = cmp_key;
            end else if (cmp_vld && cmp_last) begin
                state_d = DONE;
                hit_d   = 1'b0;
                key_d   = '0;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    assign bus.lut_en  = state_q == SCAN;
    assign bus.lut_key = state_q == SCAN ? cnt_q : '0;
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = state_q == DONE;
    assign bus.hit     = hit_q;
    assign bus.key_out = key_q;
endmodule

// File: tb/tb_acc_lut_search.sv
// tb_acc_lut_search: table vectors, corner sequences and random targets checked against a first-match search model
module tb_acc_lut_search;
`ifdef ACC_LUT_SEARCH_REGIN_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [7:0] t;
        logic       h;
        logic [4:0] k;
        int         lat;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [7:0] lut [32];
    vec_t tbl [7];
    int vectors = 0;
    int miscompares = 0;

    acc_lut_search_if bus ();

    acc_lut_search dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.lut_value = lut[bus.lut_key];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input logic [7:0] t, output logic h, output logic [4:0] k, output int lat);
        h = 1'b0;
        k = '0;
        lat = 33 + P;
        for (int i = 31; i >= 0; i--) begin
            if (lut[i] == t) begin
                h = 1'b1;
                k = i[4:0];
                lat = i + 2 + P;
            end
        end
    endfunction

    task automatic run(input logic [7:0] t, input logic h, input logic [4:0] k, input int lat,
                       input bit noise, input string tag);
        int got = -1;
        int en_cnt = 0;
        int bad = 0;
        int ek;
        logic gh = 1'b0;
        logic [4:0] gk = '0;
        bus.start = 1'b1;
        bus.target = t;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = noise && (c == 2 || c == 3);
            if (noise) bus.target = 8'hFF;
            ek = (c - 1 > 31) ? 31 : c - 1;
            if (bus.lut_en) begin
                en_cnt++;
                if (bus.lut_key !== ek[4:0]) bad++;
            end
            if (bus.busy !== 1'b1) bad++;
            if (bus.done === 1'b1) begin
                got = c;
                gh = bus.hit;
                gk = bus.key_out;
                break;
            end
        end
        chk({tag, "_latency"}, got, lat);
        chk({tag, "_hit"}, {31'd0, gh}, {31'd0, h});
        chk({tag, "_key"}, {27'd0, gk}, {27'd0, k});
        chk({tag, "_lut_en_cycles"}, en_cnt, lat - 1);
        chk({tag, "_scan_seq_errors"}, bad, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy_done"}, {30'd0, bus.busy, bus.done}, 0);
        chk({tag, "_held_result"}, {26'd0, bus.hit, bus.key_out}, {26'd0, h, k});
    endtask

    initial begin
        logic h;
        logic [4:0] k;
        int lat;
        logic [7:0] t;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.target = '0;
        for (int i = 0; i < 32; i++) lut[i] = 8'h00;
        lut[0] = 8'hFF; lut[1] = 8'd63; lut[2] = 8'h00; lut[3] = 8'd64;
        lut[4] = 8'h01; lut[5] = 8'd65; lut[6] = 8'd66; lut[7] = 8'h7F;
        lut[8] = 8'h02; lut[9] = 8'h04; lut[10] = 8'h08; lut[11] = 8'h10;
        lut[12] = 8'h20; lut[13] = 8'd64; lut[14] = 8'hC0; lut[15] = 8'hAA;
        lut[20] = 8'd66; lut[31] = 8'h55;
        tbl[0] = '{8'hFF, 1'b1, 5'd0, 2 + P};
        tbl[1] = '{8'd66, 1'b1, 5'd6, 8 + P};
        tbl[2] = '{8'h00, 1'b1, 5'd2, 4 + P};
        tbl[3] = '{8'h80, 1'b0, 5'd0, 33 + P};
        tbl[4] = '{8'h55, 1'b1, 5'd31, 33 + P};
        tbl[5] = '{8'd64, 1'b1, 5'd3, 5 + P};
        tbl[6] = '{8'hAA, 1'b1, 5'd15, 17 + P};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {17'd0, bus.lut_en, bus.lut_key, bus.busy, bus.done, bus.hit, bus.key_out}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run(tbl[i].t, tbl[i].h, tbl[i].k, tbl[i].lat, 1'b0, $sformatf("tbl%0d", i));

        run(8'd63, 1'b1, 5'd1, 3 + P, 1'b1, "ignore_start");

        run(8'd66, 1'b1, 5'd6, 8 + P, 1'b0, "pre_reset");
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_clears_result", {26'd0, bus.hit, bus.key_out}, 0);
        rst_n = 1'b1;

        bus.start = 1'b1;
        bus.target = 8'h80;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("midscan_key_c10", {27'd0, bus.lut_key}, 9);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midscan_reset_outputs", {17'd0, bus.lut_en, bus.lut_key, bus.busy, bus.done, bus.hit, bus.key_out}, 0);
        rst_n = 1'b1;
        run(8'd65, 1'b1, 5'd5, 7 + P, 1'b0, "after_reset");

        for (int n = 0; n < 60; n++) begin
            t = ($urandom_range(0, 1) == 1) ? lut[$urandom_range(0, 31)] : 8'($urandom_range(0, 255));
            model(t, h, k, lat);
            run(t, h, k, lat, ($urandom_range(0, 3) == 0), $sformatf("rand%0d_t%0d", n, t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
